// File: rtl/cpc_mmr_rom_latch.sv
// CPC paging register capture: Gate Array RAM-configuration write and the DFxx upper-ROM select.
// Optional macro CPC_RAM_EXP_512K_EN adds the ram_ext 64K block select for the 512K expansion.
module cpc_mmr_rom_latch #(
    parameter int unsigned EXP_ROM_SLOT = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        iorq_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [7:0]  data_from_cpu,
    output logic [2:0]  ram_bank,
    output logic [2:0]  ram_ext,
    output logic [7:0]  upper_rom,
    output logic        exp_rom_sel,
    output logic        mmr_wr_stb,
    output logic        rom_wr_stb
);

    localparam logic [7:0] EXP_SLOT_C = 8'(EXP_ROM_SLOT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_END = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        io_wr_s;
    logic        commit_s;
    logic        mmr_hit_s;
    logic        rom_hit_s;
    logic [2:0]  ram_bank_q;
    logic [7:0]  upper_rom_q;
    logic        mmr_stb_q;
    logic        rom_stb_q;
    logic        unused_addr_s;

    // An interrupt acknowledge drives /IORQ low with /M1 low and is never a write.
    assign io_wr_s       = ~iorq_n & ~wr_n & m1_n;
    assign unused_addr_s = ^{cpu_addr[14], cpu_addr[12:0]};

    // Next-state logic; commit_s marks the QUAL->COMMIT edge where bus values are captured.
    always_comb begin
        state_d  = state_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_wr_s) begin
                    state_d = ST_QUAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUAL: begin
                if (io_wr_s) begin
                    state_d  = ST_COMMIT;
                    commit_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (io_wr_s) begin
                    state_d = ST_WAIT_END;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mmr_hit_s = commit_s & ~cpu_addr[15] & (data_from_cpu[7:6] == 2'b11);
    assign rom_hit_s = commit_s & ~cpu_addr[13];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Paging registers and their one-clock commit strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_bank_q  <= 3'd0;
            upper_rom_q <= 8'd0;
            mmr_stb_q   <= 1'b0;
            rom_stb_q   <= 1'b0;
        end else begin
            mmr_stb_q <= mmr_hit_s;
            rom_stb_q <= rom_hit_s;
            if (mmr_hit_s) begin
                ram_bank_q <= data_from_cpu[2:0];
            end
            if (rom_hit_s) begin
                upper_rom_q <= data_from_cpu;
            end
        end
    end

`ifdef CPC_RAM_EXP_512K_EN
    logic [2:0] ram_ext_q;

    // Expansion block select shares the MMR commit with ram_bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_ext_q <= 3'd0;
        end else if (mmr_hit_s) begin
            ram_ext_q <= data_from_cpu[5:3];
        end
    end

    assign ram_ext = ram_ext_q;
`else
    assign ram_ext = 3'b000;
`endif

    assign ram_bank    = ram_bank_q;
    assign upper_rom   = upper_rom_q;
    assign mmr_wr_stb  = mmr_stb_q;
    assign rom_wr_stb  = rom_stb_q;
    assign exp_rom_sel = (upper_rom_q == EXP_SLOT_C);

endmodule

// File: tb/tb_cpc_mmr_rom_latch.sv
// Scoreboard bench for cpc_mmr_rom_latch: directed test-plan writes followed by random I/O traffic.
module tb_cpc_mmr_rom_latch;

    localparam int unsigned EXP = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        iorq_n, wr_n, m1_n;
    logic [7:0]  data_from_cpu;
    logic [2:0]  ram_bank, ram_ext;
    logic [7:0]  upper_rom;
    logic        exp_rom_sel, mmr_wr_stb, rom_wr_stb;

    cpc_mmr_rom_latch #(.EXP_ROM_SLOT(EXP)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .iorq_n(iorq_n), .wr_n(wr_n),
        .m1_n(m1_n), .data_from_cpu(data_from_cpu), .ram_bank(ram_bank), .ram_ext(ram_ext),
        .upper_rom(upper_rom), .exp_rom_sel(exp_rom_sel), .mmr_wr_stb(mmr_wr_stb),
        .rom_wr_stb(rom_wr_stb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         mmr;
        bit         rom;
        logic [2:0] bank;
        logic [2:0] ext;
        logic [7:0] urom;
    } exp_t;

    exp_t       sbq[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] m_bank, m_ext;
    logic [7:0] m_rom;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the oldest outstanding expected commit.
    always @(negedge clk) begin
        if (reset_n && (mmr_wr_stb || rom_wr_stb)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_strobe", {30'd0, mmr_wr_stb, rom_wr_stb}, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("strobe_cycle", cyc, e.at);
                chk("mmr_wr_stb", int'(mmr_wr_stb), int'(e.mmr));
                chk("rom_wr_stb", int'(rom_wr_stb), int'(e.rom));
                chk("ram_bank@stb", int'(ram_bank), int'(e.bank));
                chk("ram_ext@stb", int'(ram_ext), int'(e.ext));
                chk("upper_rom@stb", int'(upper_rom), int'(e.urom));
                chk("exp_rom_sel@stb", int'(exp_rom_sel), int'(e.urom == 8'(EXP)));
            end
        end
    end

    task automatic model_reset();
        m_bank = 3'd0;
        m_ext  = 3'd0;
        m_rom  = 8'd0;
        sbq.delete();
    endtask

    // Apply a write decision to the reference model and queue the expected strobe.
    task automatic model_write(input logic [15:0] a, input logic [7:0] d, input int at);
        bit   is_mmr, is_rom;
        exp_t e;
        is_mmr = (a[15] == 1'b0) && (d[7:6] == 2'b11);
        is_rom = (a[13] == 1'b0);
        if (is_mmr) begin
            m_bank = d[2:0];
`ifdef CPC_RAM_EXP_512K_EN
            m_ext = d[5:3];
`endif
        end
        if (is_rom) m_rom = d;
        if (is_mmr || is_rom) begin
            e.at = at; e.mmr = is_mmr; e.rom = is_rom;
            e.bank = m_bank; e.ext = m_ext; e.urom = m_rom;
            sbq.push_back(e);
        end
    endtask

    task automatic check_steady(input string tag);
        chk({tag, "_pending"}, sbq.size(), 0);
        sbq.delete();
        chk({tag, "_ram_bank"}, int'(ram_bank), int'(m_bank));
        chk({tag, "_ram_ext"}, int'(ram_ext), int'(m_ext));
        chk({tag, "_upper_rom"}, int'(upper_rom), int'(m_rom));
        chk({tag, "_exp_rom_sel"}, int'(exp_rom_sel), int'(m_rom == 8'(EXP)));
        chk({tag, "_strobes"}, int'({mmr_wr_stb, rom_wr_stb}), 0);
    endtask

    // Drive one bus cycle: d0 during the first sampled edge, d1 afterwards; n sampled edges active.
    task automatic io_write(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input int n, input bit m1, input int gap, input string tag);
        cpu_addr      = a;
        data_from_cpu = d0;
        iorq_n = 1'b0; wr_n = 1'b0; m1_n = m1;
        if (m1 && n >= 2) model_write(a, d1, cyc + 2);
        step();
        data_from_cpu = d1;
        for (int i = 1; i < n; i++) step();
        iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        repeat (gap) step();
        check_steady(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ram_bank"}, int'(ram_bank), 0);
        chk({tag, "_ram_ext"}, int'(ram_ext), 0);
        chk({tag, "_upper_rom"}, int'(upper_rom), 0);
        chk({tag, "_strobes"}, int'({mmr_wr_stb, rom_wr_stb}), 0);
        chk({tag, "_exp_rom_sel"}, int'(exp_rom_sel), int'(EXP == 0));
    endtask

    initial begin
        logic [15:0] a;
        reset_n = 1'b0;
        cpu_addr = 16'h0000; data_from_cpu = 8'h00;
        iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        model_reset();
        step(); step();
        check_reset_values("reset");
        reset_n = 1'b1;
        step();

        io_write(16'h7F00, 8'hC4, 8'hC4, 3, 1'b1, 3, "ga_c4");
        io_write(16'hDF00, 8'h07, 8'h07, 2, 1'b1, 2, "rom_07");
        io_write(16'hDF00, 8'h00, 8'h00, 2, 1'b1, 2, "rom_00");
        io_write(16'h7F00, 8'h8D, 8'h8D, 3, 1'b1, 2, "ga_mode");
        io_write(16'h7F00, 8'hC7, 8'hC7, 1, 1'b1, 3, "glitch");
        io_write(16'h7F00, 8'hC6, 8'hC6, 3, 1'b0, 2, "int_ack");
        io_write(16'h5F00, 8'hC2, 8'hC2, 2, 1'b1, 2, "both");
        io_write(16'h7F00, 8'hFF, 8'hFF, 2, 1'b1, 2, "ga_ff");
        io_write(16'h7F00, 8'hC3, 8'hC3, 2, 1'b1, 2, "ga_c3");

        // Reset during QUAL, then release with the write still held.
        cpu_addr = 16'h7F00; data_from_cpu = 8'hC1;
        iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        model_reset();
        step(); step();
        reset_n = 1'b1;
        model_write(16'h7F00, 8'hC1, cyc + 2);
        step(); step(); step();
        iorq_n = 1'b1; wr_n = 1'b1;
        step(); step();
        check_steady("after_reset");

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 3))
                0: a = 16'h7F00 | 16'($urandom_range(0, 255));
                1: a = 16'hDF00 | 16'($urandom_range(0, 255));
                2: a = 16'h5F00;
                default: a = 16'($urandom);
            endcase
            io_write(a, 8'($urandom), 8'($urandom), $urandom_range(1, 4),
                     ($urandom_range(0, 7) != 0), $urandom_range(2, 4), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
